// File: rtl/axi_rd_burst_master.sv
// AXI4 read-only INCR burst master for instruction refill; streams R beats to the requester.
// Optional macro AXI_RD_PROTO_CHECK_EN adds RLAST/RID consistency checks folded into done_err.
module axi_rd_burst_master #(
  parameter int C_M_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int MST_ID             = 0
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                    req_len,
  output logic                          rbeat_valid,
  input  logic                          rbeat_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rbeat_data,
  output logic                          rbeat_last,
  output logic                          done,
  output logic                          done_err,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST
);

  localparam int SIZE = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [C_M_AXI_ID_WIDTH-1:0]   ARID_C     = C_M_AXI_ID_WIDTH'(MST_ID);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = {C_M_AXI_ADDR_WIDTH{1'b1}} << SIZE;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                        state_q;
  logic                          arvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                    arlen_q;
  logic [7:0]                    cnt_q;
  logic                          err_q;
  logic                          done_q;
  logic                          done_err_q;

  logic       in_data;
  logic       last_beat;
  logic       beat_hs;
  logic       beat_err;
  logic       err_d;
  logic [7:0] cnt_d;

  // Gating with reset keeps the R side quiet during a mid-burst reset cycle.
  assign in_data   = (state_q == S_DATA) && !M_AXI_ARESET;
  assign last_beat = (cnt_q == arlen_q);
  assign beat_hs   = in_data && M_AXI_RVALID && rbeat_ready;
  assign cnt_d     = last_beat ? cnt_q : cnt_q + 8'd1;
  assign err_d     = err_q | beat_err;

`ifdef AXI_RD_PROTO_CHECK_EN
  always_comb begin
    beat_err = (M_AXI_RRESP != 2'b00);
    beat_err = beat_err | (M_AXI_RLAST != last_beat) | (M_AXI_RID != ARID_C);
  end
`else
  logic unused_proto;
  assign unused_proto = ^{M_AXI_RLAST, M_AXI_RID};
  always_comb begin
    beat_err = (M_AXI_RRESP != 2'b00);
  end
`endif

  assign req_ready     = (state_q == S_IDLE) && !M_AXI_ARESET;
  assign rbeat_valid   = in_data && M_AXI_RVALID;
  assign rbeat_data    = M_AXI_RDATA;
  assign rbeat_last    = in_data && last_beat;
  assign M_AXI_RREADY  = in_data && rbeat_ready;
  assign done          = done_q;
  assign done_err      = done_err_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = ARID_C;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = 2'b01;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q    <= S_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q     <= 1'b0;
          done_err_q <= 1'b0;
          if (req_valid) begin
            araddr_q  <= req_addr & ALIGN_MASK;
            arlen_q   <= req_len;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_hs) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (last_beat) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              done_err_q <= err_d;
            end
          end
        end
        S_DONE: begin
          done_q     <= 1'b0;
          done_err_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Scoreboard bench for axi_rd_burst_master: directed bursts, expected beats/AR/done queued, monitor compares.
module tb_axi_rd_burst_master;
  localparam int IDW = 4;
  localparam int DW  = 64;
  localparam int AW  = 32;

  logic           clk = 1'b0;
  logic           M_AXI_ARESET;
  logic           req_valid, req_ready;
  logic [AW-1:0]  req_addr;
  logic [7:0]     req_len;
  logic           rbeat_valid, rbeat_ready, rbeat_last, done, done_err;
  logic [DW-1:0]  rbeat_data;
  logic           M_AXI_ARVALID, M_AXI_ARREADY;
  logic [IDW-1:0] M_AXI_ARID, M_AXI_RID;
  logic [AW-1:0]  M_AXI_ARADDR;
  logic [7:0]     M_AXI_ARLEN;
  logic [2:0]     M_AXI_ARSIZE;
  logic [1:0]     M_AXI_ARBURST;
  logic           M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;
  logic [DW-1:0]  M_AXI_RDATA;
  logic [1:0]     M_AXI_RRESP;

  always #5 clk = ~clk;

  axi_rd_burst_master #(
    .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .MST_ID(0)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready), .rbeat_data(rbeat_data),
    .rbeat_last(rbeat_last), .done(done), .done_err(done_err),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       beat_q[$];
  logic [39:0] ar_q[$];
  logic        err_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ar_hs    = 0;
  int exp_ars  = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int burst_no = 0;
  bit tog      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat, AR handshake or done.
  always @(negedge clk) begin
    beat_t       b;
    logic [39:0] a;
    logic        e;
    if (!M_AXI_ARESET) begin
      if (rbeat_valid && rbeat_ready) begin
        if (beat_q.size() == 0) timeout("unexpected_beat");
        else begin
          b = beat_q.pop_front();
          chk("beat_data", rbeat_data, b.data);
          chk("beat_last", rbeat_last, 64'(b.last));
        end
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_hs++;
        if (ar_q.size() == 0) timeout("unexpected_ar");
        else begin
          a = ar_q.pop_front();
          chk("araddr", M_AXI_ARADDR, 64'(a[39:8]));
          chk("arlen", M_AXI_ARLEN, 64'(a[7:0]));
          chk("arid", M_AXI_ARID, 64'd0);
        end
      end
      if (done) begin
        done_cnt++;
        if (err_q.size() == 0) timeout("unexpected_done");
        else begin
          e = err_q.pop_front();
          chk("done_err", done_err, 64'(e));
        end
      end
    end
  end

  // Requester backpressure generator; runs later in the cycle than the main driver.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tog) rbeat_ready = ~rbeat_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // abort_after >= 0: assert reset right after that beat's handshake instead of finishing.
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                          input int err_beat, input int last_fault, input bit tog_rr,
                          input int abort_after);
    logic [31:0] aligned;
    logic        exp_err;
    int          to;
    aligned = addr & 32'hFFFF_FFF8;
    burst_no++;
    ar_q.push_back({aligned, len});
    exp_ars++;
    for (int i = 0; i <= int'(len); i++) begin
      if (abort_after < 0 || i <= abort_after)
        beat_q.push_back('{data: {32'(burst_no), 32'(32'hA0 + i)}, last: (i == int'(len))});
    end
    exp_err = (err_beat >= 0);
`ifdef AXI_RD_PROTO_CHECK_EN
    exp_err = exp_err | (last_fault >= 0);
`endif
    if (abort_after < 0) begin
      err_q.push_back(exp_err);
      exp_done++;
    end

    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    to = 0;
    @(negedge clk);
    while (!req_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    if (to >= 50) timeout("req_ready_wait");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_len   = 8'hFF;
    @(negedge clk);
    chk("arvalid_latency", M_AXI_ARVALID, 64'd1);
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge clk);
      chk("arvalid_held", M_AXI_ARVALID, 64'd1);
      chk("araddr_held", M_AXI_ARADDR, 64'(aligned));
      chk("arlen_held", M_AXI_ARLEN, 64'(len));
    end
    @(posedge clk);
    #1;
    M_AXI_ARREADY = 1'b1;
    @(posedge clk);
    #1;
    M_AXI_ARREADY = 1'b0;
    @(negedge clk);
    chk("arvalid_drop", M_AXI_ARVALID, 64'd0);
    @(posedge clk);
    #1;
    tog = tog_rr;

    for (int i = 0; i <= int'(len); i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = {32'(burst_no), 32'(32'hA0 + i)};
      M_AXI_RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
      M_AXI_RLAST  = (i == int'(len)) || (i == last_fault);
      to = 0;
      @(negedge clk);
      if (tog_rr) chk("rready_tracks", M_AXI_RREADY, 64'(rbeat_ready));
      while (!M_AXI_RREADY && to < 50) begin
        @(negedge clk);
        if (tog_rr) chk("rready_tracks", M_AXI_RREADY, 64'(rbeat_ready));
        to++;
      end
      if (to >= 50) timeout("rready_wait");
      @(posedge clk);
      #1;
      if (i == abort_after) begin
        M_AXI_ARESET = 1'b1;
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RRESP  = 2'b00;
        tog = 1'b0;
        rbeat_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 64'd0);
        chk("rst_rready", M_AXI_RREADY, 64'd0);
        chk("rst_rbeat_valid", rbeat_valid, 64'd0);
        @(posedge clk);
        #1;
        M_AXI_ARESET = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 64'd1);
        chk("post_rst_arvalid", M_AXI_ARVALID, 64'd0);
        chk("post_rst_rready", M_AXI_RREADY, 64'd0);
        chk("post_rst_done", done, 64'd0);
        @(posedge clk);
        #1;
        return;
      end
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
    tog = 1'b0;
    rbeat_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 64'd1);
    @(negedge clk);
    chk("done_width", done, 64'd0);
    chk("idle_req_ready", req_ready, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    M_AXI_ARESET  = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_len       = '0;
    rbeat_ready   = 1'b1;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RID     = '0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RLAST   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 64'd0);
    chk("reset_arvalid", M_AXI_ARVALID, 64'd0);
    chk("reset_rready", M_AXI_RREADY, 64'd0);
    chk("reset_rbeat_valid", rbeat_valid, 64'd0);
    chk("reset_rbeat_last", rbeat_last, 64'd0);
    chk("reset_done", done, 64'd0);
    chk("reset_done_err", done_err, 64'd0);
    chk("reset_araddr", M_AXI_ARADDR, 64'd0);
    chk("reset_arlen", M_AXI_ARLEN, 64'd0);
    @(posedge clk);
    #1;
    M_AXI_ARESET = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 64'd1);
    chk("arsize", M_AXI_ARSIZE, 64'd3);
    chk("arburst", M_AXI_ARBURST, 64'd1);
    chk("arid_const", M_AXI_ARID, 64'd0);
    @(posedge clk);
    #1;

    do_burst(32'h8000_0004, 8'd0, 0, -1, -1, 1'b0, -1);
    do_burst(32'h8000_1000, 8'd3, 2, -1, -1, 1'b0, -1);
    do_burst(32'h8000_2008, 8'd7, 0, -1, -1, 1'b1, -1);
    do_burst(32'h8000_3000, 8'd3, 0,  1, -1, 1'b0, -1);
    do_burst(32'h8000_4000, 8'd3, 1, -1, -1, 1'b0, -1);
    do_burst(32'h8000_5000, 8'd3, 0, -1, -1, 1'b0,  1);
    do_burst(32'h8000_6000, 8'd1, 0, -1, -1, 1'b0, -1);
    do_burst(32'h8000_7000, 8'd3, 0, -1,  2, 1'b0, -1);

    repeat (3) @(negedge clk);
    chk("beats_left", 64'(beat_q.size()), 64'd0);
    chk("ar_left", 64'(ar_q.size()), 64'd0);
    chk("done_left", 64'(err_q.size()), 64'd0);
    chk("ar_handshakes", 64'(ar_hs), 64'(exp_ars));
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
- AXI4 read-only burst master. Sits directly upstream of the DPI-backed AXI4 slave memory on the instruction-fetch path.
- Takes one refill request (base address, beat count) from the ICache/IFU, issues a single INCR burst on AR, and streams R beats back to the requester with backpressure.
- Signals completion and error once the burst ends.
- Beat counting and last-beat detection use an internal counter; slave RLAST is not relied on.

Parameters:
- C_M_AXI_ID_WIDTH, 4, width of ARID/RID
- C_M_AXI_DATA_WIDTH, 64, R data width (32 or 64)
- C_M_AXI_ADDR_WIDTH, 32, address width
- MST_ID, 0, constant ARID value for every burst

Ports:
- M_AXI_ACLK  input  1  clock
- M_AXI_ARESET  input  1  synchronous active-high reset
- req_valid  input  1  refill request valid
- req_ready  output  1  block idle, request accepted on valid&&ready
- req_addr  input  C_M_AXI_ADDR_WIDTH  burst base byte address
- req_len  input  8  beats minus one (AXI ARLEN encoding)
- rbeat_valid  output  1  read beat valid (mirrors RVALID in DATA)
- rbeat_ready  input  1  requester accepts beat
- rbeat_data  output  C_M_AXI_DATA_WIDTH  beat data (RDATA passthrough)
- rbeat_last  output  1  final beat of burst (internal counter)
- done  output  1  one-cycle pulse after final beat
- done_err  output  1  valid with done: any beat had RRESP!=OKAY
- M_AXI_ARVALID  output  1  read address valid
- M_AXI_ARREADY  input  1  read address ready
- M_AXI_ARID  output  C_M_AXI_ID_WIDTH  constant MST_ID
- M_AXI_ARADDR  output  C_M_AXI_ADDR_WIDTH  latched aligned address
- M_AXI_ARLEN  output  8  latched req_len
- M_AXI_ARSIZE  output  3  log2(C_M_AXI_DATA_WIDTH/8), constant
- M_AXI_ARBURST  output  2  2'b01 INCR, constant
- M_AXI_RVALID  input  1  read data valid
- M_AXI_RREADY  output  1  read data ready
- M_AXI_RID  input  C_M_AXI_ID_WIDTH  read ID
- M_AXI_RDATA  input  C_M_AXI_DATA_WIDTH  read data
- M_AXI_RRESP  input  2  read response
- M_AXI_RLAST  input  1  slave last flag (used only by optional check)

Behaviour:
- Clocking: single clock M_AXI_ACLK; reset M_AXI_ARESET is synchronous, active-high.
- FSM states:
  - IDLE -> ADDR on req_valid.
  - ADDR -> DATA on ARVALID&&ARREADY.
  - DATA -> DONE on final R handshake.
  - DONE -> IDLE unconditionally.
- Reset values: state IDLE; ARVALID=0, RREADY=0, rbeat_valid=0, rbeat_last=0, done=0, done_err=0; req_ready=0 during the reset cycle. Beat counter, err flag, ARADDR and ARLEN registers are 0.
- req_ready = (state==IDLE) && !M_AXI_ARESET.
- On request accept, latch:
  - ARADDR = req_addr with low log2(DW/8) bits forced to 0.
  - ARLEN = req_len.
  - beat counter = 0, err = 0.
- Latency: request accepted in cycle N; ARVALID=1 registered in cycle N+1.
- ADDR: ARVALID held high and ARADDR/ARLEN/ARID held stable until ARREADY. ARVALID drops the cycle after the handshake.
- DATA handshake:
  - RREADY = rbeat_ready (combinational); rbeat_valid = RVALID; rbeat_data = RDATA. No buffering, zero added latency.
  - Counter increments on RVALID&&RREADY; 8-bit, no wrap (max 255 == len).
  - rbeat_last = (cnt==ARLEN) while in DATA.
  - err |= (RRESP!=2'b00) on each handshake.
- Final beat: handshake with cnt==ARLEN -> DONE. Beats after that are not accepted, because RREADY=0 outside DATA.
- DONE: done=1 and done_err=err for exactly one cycle, then IDLE. Minimum gap between bursts is one cycle, since req_ready only asserts in IDLE.
- req_len=0: single beat, rbeat_last=1 on the first beat.
- ARID held at MST_ID for the whole burst.
- The 4 KB boundary is not checked; the requester guarantees bursts do not cross it.
- Reset mid-burst: immediate return to IDLE, all outputs at reset values. The slave is reset in the same cycle.

Optional Feature:
- Macro: AXI_RD_PROTO_CHECK_EN.
- Defined: on each R handshake, also set err if M_AXI_RLAST != (cnt==ARLEN) or M_AXI_RID != MST_ID. The error is reported via done_err. Burst termination still follows the internal counter.
- Undefined: RLAST and RID are ignored and no check logic is generated.

Test Plan:
- req_addr=0x80000004, req_len=0, rbeat_ready=1 -> ARADDR=0x80000000, ARLEN=0, one beat with rbeat_last=1, done pulse with done_err=0.
- req_addr=0x80001000, req_len=3, slave memory words 0xA0..0xA3 -> four beats in order, rbeat_last only on 0xA3, ARVALID exactly one handshake, done one cycle after the last beat.
- req_len=7, rbeat_ready toggled 1/0 every cycle -> RREADY tracks rbeat_ready, all 8 beats delivered without loss or duplicate, done once.
- req_len=3, slave RRESP=2'b10 on beat 1 -> all 4 beats delivered, done_err=1; next clean burst -> done_err=0.
- Reset asserted for 1 cycle in DATA after beat 1 of len=3 -> next cycle state IDLE, ARVALID=0, RREADY=0, req_ready=1; a new len=1 request completes normally.
- With AXI_RD_PROTO_CHECK_EN: slave RLAST=1 on beat 2 of len=3 -> done_err=1 and 4 beats still consumed; without the macro -> done_err=0.
